fetch_unit: RTL

//   Instruction fetch stage directly upstream of the controller. Owns the PC register, drives a
//   req/ack instruction-memory port and presents one instruction (opcode/funct fields) to decode.

---
 rtl/fetch_unit_pkg.sv | 16 +
 rtl/fetch_unit_npc_calc.sv | 43 ++++
 rtl/fetch_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   NPC_SEL_* : next-PC select encodings, shared with the controller
//   br_offset : beq byte offset built from the 16-bit word offset
package fetch_unit_pkg;

    localparam logic [1:0] NPC_SEL_ADD4 = 2'b00;
    localparam logic [1:0] NPC_SEL_BEQ  = 2'b01;
    localparam logic [1:0] NPC_SEL_J    = 2'b10;
    localparam logic [1:0] NPC_SEL_REG  = 2'b11;

    // Sign-extend the word offset and scale it to bytes.
    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_npc_calc.sv
// npc_calc: combinational next-PC selection.
// Ports:
//   i_pc         current PC
//   i_npc_sel    next-PC select (NPC_SEL_*)
//   i_imm16      beq word offset
//   i_target26   j/jal word target
//   i_reg_addr   jr register target
//   o_pc_plus4   PC+4
//   o_next_pc    selected next PC
//   o_misaligned next PC is not word aligned
module npc_calc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [1:0]  i_npc_sel,
    input  logic [15:0] i_imm16,
    input  logic [25:0] i_target26,
    input  logic [31:0] i_reg_addr,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_next_pc,
    output logic        o_misaligned
);

    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = i_pc + 32'd4;
    assign o_pc_plus4 = w_pc_plus4;

    always_comb begin
        o_next_pc = w_pc_plus4;
        case (i_npc_sel)
            NPC_SEL_ADD4: o_next_pc = w_pc_plus4;
            NPC_SEL_BEQ:  o_next_pc = w_pc_plus4 + br_offset(i_imm16);
            NPC_SEL_J:    o_next_pc = {w_pc_plus4[31:28], i_target26, 2'b00};
            NPC_SEL_REG:  o_next_pc = i_reg_addr;
            default:      o_next_pc = w_pc_plus4;
        endcase
    end

    // Only the register jump can produce a non-word-aligned target.
    assign o_misaligned = |o_next_pc[1:0];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, fetches one instruction
// over a req/ack port, holds it for decode until commit, then applies NPCSel.
// Ports:
//   clk, rst              clock, async active-high reset
//   NPCSel, Imm16,        next-PC controls, sampled on commit
//   Target26, RegAddr
//   commit                core retires Instr this cycle
//   imem_req/addr         fetch request (high in S_FETCH) and address (= PC)
//   imem_rdata/ack        returned instruction word and its strobe
//   Instr, InstrValid     instruction for decode and its valid flag
//   PC, PCPlus4           address of Instr and PC+4
//   addr_err, bus_err     sticky misaligned-target / fetch-timeout flags
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_3000,
    parameter int unsigned FETCH_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  NPCSel,
    input  logic [15:0] Imm16,
    input  logic [25:0] Target26,
    input  logic [31:0] RegAddr,
    input  logic        commit,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        addr_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_valid;
    logic        r_addr_err;
    logic        r_bus_err;
    logic [31:0] r_tmo_cnt;

    logic [31:0] w_next_pc;
    logic        w_misaligned;
    logic        w_tmo_hit;

    npc_calc u_npc_calc (
        .i_pc         (r_pc),
        .i_npc_sel    (NPCSel),
        .i_imm16      (Imm16),
        .i_target26   (Target26),
        .i_reg_addr   (RegAddr),
        .o_pc_plus4   (PCPlus4),
        .o_next_pc    (w_next_pc),
        .o_misaligned (w_misaligned)
    );

    // Last permitted cycle without ack; a zero timeout never fires.
    assign w_tmo_hit = (FETCH_TIMEOUT != 0) && (r_tmo_cnt == FETCH_TIMEOUT - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT:  w_state_nxt = S_FETCH;
            // Ack takes priority over a simultaneous timeout.
            S_FETCH: begin
                if (imem_ack)       w_state_nxt = S_ISSUE;
                else if (w_tmo_hit) w_state_nxt = S_HALT;
            end
            S_ISSUE: begin
                if (commit) w_state_nxt = w_misaligned ? S_HALT : S_FETCH;
            end
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_valid    <= 1'b0;
            r_addr_err <= 1'b0;
            r_bus_err  <= 1'b0;
            r_tmo_cnt  <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ack) begin
                        r_instr   <= imem_rdata;
                        r_valid   <= 1'b1;
                        r_tmo_cnt <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 32'd1;
                        if (w_tmo_hit) r_bus_err <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (commit) begin
                        r_valid <= 1'b0;
                        // A rejected target leaves PC pointing at the faulting jr.
                        if (w_misaligned) r_addr_err <= 1'b1;
                        else              r_pc       <= w_next_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_req   = (r_state == S_FETCH);
    assign imem_addr  = r_pc;
    assign Instr      = r_instr;
    assign InstrValid = r_valid;
    assign PC         = r_pc;
    assign addr_err   = r_addr_err;
    assign bus_err    = r_bus_err;

endmodule
